temp_bram_reader: RTL
=====================

TEMP_BRAM_READER -- requirements
Module: temp_bram_reader

Interface
REQ-001 SHALL have parameter MAC_CNT, default 32: number of DATA_WIDTH entries per buffer half.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: element width in bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(MAC_CNT*2): buffer index width.
REQ-004 SHALL have parameter REP_WIDTH, default 8: width of the pass-count field.
REQ-005 SHALL have ports, in this order:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  start a transfer; sampled in IDLE only.
- abort_i  in  1  synchronous flush to IDLE.
- half_mode_i  in  2  01 = lower half, 10 = upper half, 11 = both halves, 00 = invalid.
- repeat_i  in  REP_WIDTH  number of passes; 0 is treated as 1.
- rd_temp_en_o  out  1  buffer read enable.
- temp_bram_index_o  out  ADDR_WIDTH  buffer read index.
- bram_data_i  in  DATA_WIDTH  buffer read data, valid the cycle after rd_temp_en_o.
- data_o  out  DATA_WIDTH  stream data.
- valid_o  out  1  stream valid.
- ready_i  in  1  stream ready.
- last_o  out  1  final element of each pass.
- final_o  out  1  final element of the whole transfer.
- busy_o  out  1  high in RUN and DRAIN.
- done_o  out  1  one-cycle completion pulse.

Function
REQ-006 SHALL implement a state machine with states IDLE, RUN and DRAIN.
REQ-007 In IDLE, start_i=1 with half_mode_i≠00 SHALL latch half_mode_i and repeat_i, then go to RUN; with half_mode_i=00 the start SHALL be ignored.
REQ-008 The index range SHALL be 0..MAC_CNT-1 (mode 01), MAC_CNT..2*MAC_CNT-1 (mode 10) or 0..2*MAC_CNT-1 (mode 11), read in ascending order.
REQ-009 In RUN, reads SHALL be issued only when (FIFO occupancy + reads in flight − pop this cycle) < 2, where the internal FIFO has 2 entries.
REQ-010 A read issued in cycle t SHALL push bram_data_i into the FIFO at the end of cycle t+1.
REQ-011 With ready_i held high, one read SHALL be issued per cycle and the first valid_o SHALL occur 3 cycles after the start_i cycle.
REQ-012 When the index reaches the last index of a pass:
- if passes remain, the index SHALL wrap to the first index of the range on the next read, with no bubble;
- otherwise the state SHALL go to DRAIN.
REQ-013 The stream SHALL follow AXI-style rules:
- data_o, last_o and final_o SHALL hold stable while valid_o=1 and ready_i=0;
- a beat transfers when valid_o=1 and ready_i=1.
REQ-014 last_o SHALL accompany the final index of every pass, and final_o SHALL accompany only the final beat of the final pass.
REQ-015 In DRAIN, no reads SHALL be issued; when the FIFO is empty and no read is in flight, done_o SHALL pulse for 1 cycle and the state SHALL return to IDLE.
REQ-016 start_i while busy_o=1 SHALL be ignored.
REQ-017 The pass counter SHALL be REP_WIDTH wide, and repeat_i = 2^REP_WIDTH−1 SHALL be supported without overflow.
REQ-018 abort_i=1 in any state SHALL, on the next edge:
- empty the FIFO and discard in-flight data;
- enter IDLE;
- not pulse done_o.
REQ-019 abort_i SHALL take priority over start_i in the same cycle.
REQ-020 rd_temp_en_o SHALL be 0 whenever a read is not being issued; temp_bram_index_o SHALL hold its last value.

Reset
REQ-021 While rstn_i=0, the block SHALL be in IDLE and the outputs SHALL be:
- rd_temp_en_o, valid_o, last_o, final_o, busy_o, done_o = 0;
- temp_bram_index_o, data_o = 0;
- FIFO empty, pass counter = 0.
REQ-022 Reset asserted mid-transfer SHALL abandon the transfer immediately, with no done_o after release.
REQ-023 The first start_i SHALL be accepted on the first rising edge after rstn_i deasserts.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Mode 01, repeat 1, ready=1, buffer[i]=i: data_o = 0..31 on consecutive cycles; last_o and final_o on 31; done_o one cycle after the final beat.
- Mode 11, repeat 3: 192 beats with index sequence 0..63 three times; last_o on beats 63, 127 and 191; final_o on 191 only; no bubbles.
- Mode 10 with random ready_i toggling: data_o = 32..63 in order, no loss or duplication, output stable while stalled.
- Abort after 10 beats, then a new start in mode 01: no done_o for the aborted transfer; the second transfer restarts at index 0.
- start_i with half_mode 00, and start_i while busy: both ignored, with busy_o and the in-progress sequence unchanged.
- rstn_i pulsed low mid-transfer: all outputs 0 within reset; IDLE after release.

Source files
------------

// File: rtl/temp_bram_reader.sv
// Streams a window of the temp buffer through a 2-entry skid FIFO as a valid/ready stream.
// Supports lower/upper/both halves, multiple passes, abort flush and a done pulse.
module temp_bram_reader #(
    parameter int MAC_CNT    = 32,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = $clog2(MAC_CNT*2),
    parameter int REP_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [1:0]            half_mode_i,
    input  logic [REP_WIDTH-1:0]  repeat_i,
    output logic                  rd_temp_en_o,
    output logic [ADDR_WIDTH-1:0] temp_bram_index_o,
    input  logic [DATA_WIDTH-1:0] bram_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o,
    output logic                  final_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [ADDR_WIDTH-1:0] HALF_BASE = ADDR_WIDTH'(MAC_CNT);
    localparam logic [ADDR_WIDTH-1:0] HALF_END  = ADDR_WIDTH'(MAC_CNT - 1);
    localparam logic [ADDR_WIDTH-1:0] FULL_END  = ADDR_WIDTH'(2*MAC_CNT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state, state_nxt;
    logic [1:0]              mode;
    logic [REP_WIDTH-1:0]    rep_left;
    logic [ADDR_WIDTH-1:0]   idx;
    logic                    inflight, inflight_last, inflight_final;

    logic [DATA_WIDTH-1:0]   fifo_data [2];
    logic                    fifo_last [2];
    logic                    fifo_final [2];
    logic                    wr_ptr, rd_ptr;
    logic [1:0]              count;

    logic                    accept, pop, issue, at_end;
    logic [2:0]              occ;
    logic [ADDR_WIDTH-1:0]   first_idx, end_idx, start_idx;

    assign first_idx = (mode == 2'b10) ? HALF_BASE : '0;
    assign end_idx   = (mode == 2'b01) ? HALF_END : FULL_END;
    assign start_idx = (half_mode_i == 2'b10) ? HALF_BASE : '0;
    assign at_end    = (idx == end_idx);

    assign accept = (state == IDLE) && start_i && (half_mode_i != 2'b00) && !abort_i;
    assign pop    = (count != 2'd0) && ready_i;
    // Reserve FIFO space for every read whose data is still on its way back.
    assign occ    = 3'(count) + 3'(inflight) - 3'(pop);
    assign issue  = (state == RUN) && !abort_i && (occ < 3'd2);

    assign rd_temp_en_o      = issue;
    assign temp_bram_index_o = idx;
    assign valid_o           = (count != 2'd0);
    assign data_o            = valid_o ? fifo_data[rd_ptr] : '0;
    assign last_o            = valid_o && fifo_last[rd_ptr];
    assign final_o           = valid_o && fifo_final[rd_ptr];
    assign busy_o            = (state != IDLE);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done_o    = 1'b0;
        if (abort_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (accept) state_nxt = RUN;
                RUN:   if (issue && at_end && (rep_left == '0)) state_nxt = DRAIN;
                DRAIN: if ((count == 2'd0) && !inflight) begin
                    done_o    = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mode           <= '0;
            rep_left       <= '0;
            idx            <= '0;
            inflight       <= 1'b0;
            inflight_last  <= 1'b0;
            inflight_final <= 1'b0;
            fifo_data[0]   <= '0;
            fifo_data[1]   <= '0;
            fifo_last[0]   <= 1'b0;
            fifo_last[1]   <= 1'b0;
            fifo_final[0]  <= 1'b0;
            fifo_final[1]  <= 1'b0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            count          <= '0;
        end else if (abort_i) begin
            inflight <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= '0;
        end else begin
            if (accept) begin
                mode     <= half_mode_i;
                rep_left <= (repeat_i == '0) ? '0 : repeat_i - REP_WIDTH'(1);
                idx      <= start_idx;
            end
            inflight       <= issue;
            inflight_last  <= at_end;
            inflight_final <= at_end && (rep_left == '0);
            if (issue) begin
                if (!at_end) begin
                    idx <= idx + ADDR_WIDTH'(1);
                end else if (rep_left != '0) begin
                    rep_left <= rep_left - REP_WIDTH'(1);
                    idx      <= first_idx;
                end
            end
            if (inflight) begin
                fifo_data[wr_ptr]  <= bram_data_i;
                fifo_last[wr_ptr]  <= inflight_last;
                fifo_final[wr_ptr] <= inflight_final;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(inflight) - 2'(pop);
        end
    end

endmodule
